fft_frame_loader: RTL and testbench

Serial-to-parallel front end for the 16-point FFT processor. Collects signed 16-bit audio samples one per `sample_valid` strobe, double-buffers them into 16-sample frames and presents each frame on `t0`…`t15` with a one-cycle `new_t` launch pulse. It sequences launches against the FFT's `done` output so no frame is issued while a transform is in flight, and it flags dropped frames.

---
 rtl/fft_frame_loader.sv | 148 ++++++++++++++
 tb/tb_fft_frame_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// Serial-to-parallel double-buffered frame loader for the 16-point FFT.
// Latency: the frame launches (new_t) one cycle after its 16th sample is accepted, if the FFT is idle.
// Backpressure: none on samples; if hold is still occupied when a new frame completes, that frame is dropped and overrun is set.
module fft_frame_loader #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              fft_done,
    output logic [DATA_W-1:0] t0,
    output logic [DATA_W-1:0] t1,
    output logic [DATA_W-1:0] t2,
    output logic [DATA_W-1:0] t3,
    output logic [DATA_W-1:0] t4,
    output logic [DATA_W-1:0] t5,
    output logic [DATA_W-1:0] t6,
    output logic [DATA_W-1:0] t7,
    output logic [DATA_W-1:0] t8,
    output logic [DATA_W-1:0] t9,
    output logic [DATA_W-1:0] t10,
    output logic [DATA_W-1:0] t11,
    output logic [DATA_W-1:0] t12,
    output logic [DATA_W-1:0] t13,
    output logic [DATA_W-1:0] t14,
    output logic [DATA_W-1:0] t15,
    output logic              new_t,
    output logic              busy,
    output logic              overrun,
    output logic              fft_err,
    output logic [CNT_W-1:0]  frames_launched
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_LOW  = 2'd2;
    localparam logic [1:0] S_WAIT_HIGH = 2'd3;

    // Only 15 capture words are stored: the 16th sample goes straight into hold.
    logic [DATA_W-1:0] cap  [0:14];
    logic [DATA_W-1:0] hold [0:15];
    logic [DATA_W-1:0] tq   [0:15];
    logic [3:0]        wi;
    logic              hold_full;
    logic [1:0]        state;
    logic [1:0]        ack_tmr;

    logic frame_done;
    logic launch;

    assign frame_done = sample_valid && (wi == 4'd15);
    assign launch     = (state == S_IDLE) && hold_full && fft_done;
    assign busy       = (state != S_IDLE);

    // Capture bank: write incoming samples at wi; wi wraps 15 -> 0 so capture never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            wi <= 4'd0;
            for (int k = 0; k < 15; k++) cap[k] <= '0;
        end else if (sample_valid) begin
            wi <= wi + 4'd1;
            for (int k = 0; k < 15; k++) begin
                if (wi == 4'(k)) cap[k] <= sample_in;
            end
        end
    end

    // Hold bank: accept a completed frame when empty or being launched this cycle, otherwise drop it.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k < 16; k++) hold[k] <= '0;
        end else begin
            if (frame_done && (!hold_full || launch)) begin
                for (int k = 0; k < 15; k++) hold[k] <= cap[k];
                hold[15]  <= sample_in;
                hold_full <= 1'b1;
            end else if (launch) begin
                hold_full <= 1'b0;
            end
            if (frame_done && hold_full && !launch) overrun <= 1'b1;
        end
    end

    // Launch sequencer: issue a frame only when the FFT is idle, then track its done handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            ack_tmr         <= 2'd0;
            new_t           <= 1'b0;
            fft_err         <= 1'b0;
            frames_launched <= '0;
            for (int k = 0; k < 16; k++) tq[k] <= '0;
        end else begin
            new_t <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        for (int k = 0; k < 16; k++) tq[k] <= hold[k];
                        new_t           <= 1'b1;
                        frames_launched <= frames_launched + CNT_W'(1);
                        state           <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    ack_tmr <= 2'd0;
                    state   <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    // Give the FFT three cycles to drop done before declaring a lost launch.
                    if (!fft_done) begin
                        state <= S_WAIT_HIGH;
                    end else if (ack_tmr == 2'd2) begin
                        fft_err <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        ack_tmr <= ack_tmr + 2'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (fft_done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign t0  = tq[0];
    assign t1  = tq[1];
    assign t2  = tq[2];
    assign t3  = tq[3];
    assign t4  = tq[4];
    assign t5  = tq[5];
    assign t6  = tq[6];
    assign t7  = tq[7];
    assign t8  = tq[8];
    assign t9  = tq[9];
    assign t10 = tq[10];
    assign t11 = tq[11];
    assign t12 = tq[12];
    assign t13 = tq[13];
    assign t14 = tq[14];
    assign t15 = tq[15];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader with a simple FFT done-handshake model.
// Inputs change and outputs are sampled on the falling clock edge.
// The FFT model can be responsive, held busy, or stuck idle.
module tb_fft_frame_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        fft_done;
    logic [15:0] t0, t1, t2, t3, t4, t5, t6, t7;
    logic [15:0] t8, t9, t10, t11, t12, t13, t14, t15;
    logic        new_t, busy, overrun, fft_err;
    logic [7:0]  frames_launched;

    int total = 0;
    int bad   = 0;
    int fft_mode = 0;   // 0 responsive, 1 held busy, 2 stuck idle
    int ack_cnt;
    logic prev_nt = 1'b0;
    logic [15:0] tv [16];

    always #5 clk = ~clk;

    fft_frame_loader #(.DATA_W(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .fft_done(fft_done),
        .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5), .t6(t6), .t7(t7),
        .t8(t8), .t9(t9), .t10(t10), .t11(t11), .t12(t12), .t13(t13), .t14(t14), .t15(t15),
        .new_t(new_t), .busy(busy), .overrun(overrun), .fft_err(fft_err),
        .frames_launched(frames_launched)
    );

    always_comb begin
        tv[0] = t0;   tv[1] = t1;   tv[2] = t2;   tv[3] = t3;
        tv[4] = t4;   tv[5] = t5;   tv[6] = t6;   tv[7] = t7;
        tv[8] = t8;   tv[9] = t9;   tv[10] = t10; tv[11] = t11;
        tv[12] = t12; tv[13] = t13; tv[14] = t14; tv[15] = t15;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // FFT model: sees new_t on an edge, drops done, raises it again four edges later.
    always @(posedge clk) begin
        if (reset) begin
            fft_done <= 1'b1;
            ack_cnt  <= 0;
        end else if (fft_mode == 1) begin
            fft_done <= 1'b0;
            ack_cnt  <= 0;
        end else if (fft_mode == 2) begin
            fft_done <= 1'b1;
            ack_cnt  <= 0;
        end else if (new_t) begin
            fft_done <= 1'b0;
            ack_cnt  <= 4;
        end else if (ack_cnt > 1) begin
            ack_cnt <= ack_cnt - 1;
        end else begin
            ack_cnt  <= 0;
            fft_done <= 1'b1;
        end
    end

    // new_t must never repeat on consecutive cycles nor appear while the FFT is busy.
    always @(posedge clk) begin
        if (!reset) chk("new_t_rule", {31'd0, (new_t && prev_nt) || (new_t && !fft_done)}, 32'd0);
        prev_nt <= new_t;
    end

    task automatic check_frame(input string tag, input logic [15:0] base, input logic [15:0] step);
        logic [15:0] e;
        for (int k = 0; k < 16; k++) begin
            e = base + step * 16'(k);
            chk($sformatf("%s_t%0d", tag, k), {16'd0, tv[k]}, {16'd0, e});
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_new_t"}, {31'd0, new_t}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        chk({tag, "_fft_err"}, {31'd0, fft_err}, 32'd0);
        chk({tag, "_frames"}, {24'd0, frames_launched}, 32'd0);
        check_frame(tag, 16'd0, 16'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero(tag);
    endtask

    // Sends 16 samples base + k*step with 'gap' idle cycles between strobes;
    // returns at the falling edge right after the 16th sample's acceptance edge.
    task automatic send_frame(input logic [15:0] base, input logic [15:0] step, input int gap);
        for (int i = 0; i < 16; i++) begin
            sample_in    = base + step * 16'(i);
            sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
            if (i < 15) repeat (gap) @(negedge clk);
        end
    endtask

    initial begin
        int  n;
        logic found;
        int  f;
        int  idx;

        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 16'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_zero("rst0");

        // Frame capture: 1000, 3000, ..., 31000 back-to-back
        send_frame(16'd1000, 16'd2000, 0);
        chk("cap_new_t_early", {31'd0, new_t}, 32'd0);
        @(negedge clk);
        chk("cap_new_t", {31'd0, new_t}, 32'd1);
        chk("cap_busy", {31'd0, busy}, 32'd1);
        chk("cap_frames", {24'd0, frames_launched}, 32'd1);
        chk("cap_t0_const", {16'd0, t0}, 32'd1000);
        chk("cap_t15_const", {16'd0, t15}, 32'd31000);
        check_frame("cap", 16'd1000, 16'd2000);
        @(negedge clk);
        chk("cap_new_t_off", {31'd0, new_t}, 32'd0);
        repeat (4) @(negedge clk);
        chk("cap_busy_e6", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("cap_idle_e7", {31'd0, busy}, 32'd0);

        // Gapped input: one strobe every third cycle
        send_frame(16'd1000, 16'd2000, 2);
        chk("gap_new_t_early", {31'd0, new_t}, 32'd0);
        @(negedge clk);
        chk("gap_new_t", {31'd0, new_t}, 32'd1);
        chk("gap_frames", {24'd0, frames_launched}, 32'd2);
        check_frame("gap", 16'd1000, 16'd2000);
        repeat (6) @(negedge clk);
        chk("gap_idle", {31'd0, busy}, 32'd0);

        // Overrun: frame 1 launches, FFT then held busy; frame 2 held, frame 3 dropped
        for (int i = 0; i < 48; i++) begin
            if (i == 19) fft_mode = 1;
            f   = i / 16;
            idx = i % 16;
            sample_in    = 16'(100 * (f + 1) + idx);
            sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
            if (i == 16) chk("ovr_f1_new_t", {31'd0, new_t}, 32'd1);
            if (i == 31) chk("ovr_after_f2", {31'd0, overrun}, 32'd0);
            if (i == 47) begin
                chk("ovr_after_f3", {31'd0, overrun}, 32'd1);
                chk("ovr_busy", {31'd0, busy}, 32'd1);
                chk("ovr_frames_held", {24'd0, frames_launched}, 32'd3);
            end
        end
        fft_mode = 0;
        found = 1'b0;
        n = 0;
        while (!found && n < 12) begin
            @(negedge clk);
            if (new_t) found = 1'b1;
            n++;
        end
        chk("ovr_launch_seen", {31'd0, found}, 32'd1);
        chk("ovr_t0_const", {16'd0, t0}, 32'd200);
        chk("ovr_t15_const", {16'd0, t15}, 32'd215);
        check_frame("ovr", 16'd200, 16'd1);
        chk("ovr_frames", {24'd0, frames_launched}, 32'd4);
        repeat (7) @(negedge clk);
        chk("ovr_idle", {31'd0, busy}, 32'd0);

        do_reset("rst1");

        // Completion plus launch: frame 3 completes on the edge frame 2 launches
        for (int i = 0; i < 48; i++) begin
            if (i == 19) fft_mode = 1;
            if (i == 45) fft_mode = 0;
            f   = i / 16;
            idx = i % 16;
            sample_in    = 16'(1000 * (f + 1) + idx);
            sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
            if (i == 16) chk("cpl_f1_new_t", {31'd0, new_t}, 32'd1);
        end
        chk("cpl_f2_new_t", {31'd0, new_t}, 32'd1);
        chk("cpl_f2_frames", {24'd0, frames_launched}, 32'd2);
        chk("cpl_f2_t0_const", {16'd0, t0}, 32'd2000);
        check_frame("cpl_f2", 16'd2000, 16'd1);
        chk("cpl_overrun", {31'd0, overrun}, 32'd0);
        repeat (6) @(negedge clk);
        chk("cpl_gap_new_t", {31'd0, new_t}, 32'd0);
        @(negedge clk);
        chk("cpl_f3_new_t", {31'd0, new_t}, 32'd1);
        chk("cpl_f3_frames", {24'd0, frames_launched}, 32'd3);
        chk("cpl_f3_t15_const", {16'd0, t15}, 32'd3015);
        check_frame("cpl_f3", 16'd3000, 16'd1);
        chk("cpl_overrun_end", {31'd0, overrun}, 32'd0);
        repeat (6) @(negedge clk);
        chk("cpl_idle", {31'd0, busy}, 32'd0);

        // Missing acknowledge: done stuck high
        fft_mode = 2;
        send_frame(16'hFF9C, 16'hFF9C, 0);   // -100, -200, ..., -1600
        chk("ack_err_early", {31'd0, fft_err}, 32'd0);
        @(negedge clk);
        chk("ack_new_t", {31'd0, new_t}, 32'd1);
        chk("ack_frames", {24'd0, frames_launched}, 32'd4);
        chk("ack_t15_const", {16'd0, t15}, 32'(16'hF9C0));
        check_frame("ack", 16'hFF9C, 16'hFF9C);
        repeat (3) @(negedge clk);
        chk("ack_err_e4", {31'd0, fft_err}, 32'd0);
        chk("ack_busy_e4", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("ack_err_e5", {31'd0, fft_err}, 32'd1);
        chk("ack_idle_e5", {31'd0, busy}, 32'd0);
        fft_mode = 0;
        send_frame(16'd7, 16'd11, 0);
        @(negedge clk);
        chk("ack_next_new_t", {31'd0, new_t}, 32'd1);
        chk("ack_next_frames", {24'd0, frames_launched}, 32'd5);
        chk("ack_err_sticky", {31'd0, fft_err}, 32'd1);
        check_frame("ack_next", 16'd7, 16'd11);
        repeat (6) @(negedge clk);
        chk("ack_next_idle", {31'd0, busy}, 32'd0);

        // Reset mid-operation: after 9 samples, then while waiting for done to rise
        for (int i = 0; i < 9; i++) begin
            sample_in    = 16'h2222;
            sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
        end
        do_reset("rst2");
        send_frame(16'd400, 16'd3, 0);
        @(negedge clk);
        chk("rmo_new_t", {31'd0, new_t}, 32'd1);
        chk("rmo_frames", {24'd0, frames_launched}, 32'd1);
        check_frame("rmo", 16'd400, 16'd3);
        repeat (2) @(negedge clk);
        chk("rmo_busy_wh", {31'd0, busy}, 32'd1);
        do_reset("rst3");
        send_frame(16'h8000, 16'h0101, 0);
        chk("rmo2_new_t_early", {31'd0, new_t}, 32'd0);
        @(negedge clk);
        chk("rmo2_new_t", {31'd0, new_t}, 32'd1);
        chk("rmo2_frames", {24'd0, frames_launched}, 32'd1);
        chk("rmo2_t0_const", {16'd0, t0}, 32'h8000);
        check_frame("rmo2", 16'h8000, 16'h0101);
        repeat (6) @(negedge clk);
        chk("rmo2_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
